// File: rtl/regwrite_arbiter.sv
// Two-requester register-file write arbiter with a destination-register
// scoreboard. Grants one writeback per cycle round-robin, registers the
// winning write for the register file, and flags hazards/unreserved writes.
module regwrite_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_reg,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_reg,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        reserve_valid,
  input  logic [4:0]  reserve_reg,
  input  logic [4:0]  query_reg1,
  input  logic [4:0]  query_reg2,
  output logic        hazard1,
  output logic        hazard2,
  output logic        RegWrite,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        err_unreserved
);

  localparam int unsigned NREGS = 32;

  logic             prio;
  logic [NREGS-1:1] pending;
  logic [NREGS-1:0] pend_full;
  logic [NREGS-1:0] pend_next;
  logic             xfer;
  logic [4:0]       sel_reg;
  logic [31:0]      sel_data;
  logic             sel_nonzero;

  // Register 0 is never pending; widening with a zero LSB makes lookups uniform.
  assign pend_full = {pending, 1'b0};

  // Round-robin grant; nothing is granted while reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset) begin
      if (req0_valid && (!req1_valid || !prio)) begin
        req0_ready = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
      end
    end
  end

  // Winning transfer payload.
  always_comb begin
    xfer        = req0_ready | req1_ready;
    sel_reg     = req1_ready ? req1_reg  : req0_reg;
    sel_data    = req1_ready ? req1_data : req0_data;
    sel_nonzero = (sel_reg != 5'd0);
  end

  // Hazards read current scoreboard state only (no same-cycle forwarding).
  always_comb begin
    hazard1 = pend_full[query_reg1];
    hazard2 = pend_full[query_reg2];
  end

  // Next scoreboard: clear on write, then set on reserve so a same-register reserve wins.
  always_comb begin
    pend_next = pend_full;
    if (xfer && sel_nonzero) begin
      pend_next[sel_reg] = 1'b0;
    end
    if (reserve_valid && (reserve_reg != 5'd0)) begin
      pend_next[reserve_reg] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  // Priority pointer flips away from whichever requester just transferred.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (req0_ready) begin
      prio <= 1'b1;
    end else if (req1_ready) begin
      prio <= 1'b0;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pend_next[NREGS-1:1];
    end
  end

  // Registered register-file write port; address/data hold when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      RegWrite   <= 1'b0;
      write_reg  <= 5'd0;
      write_data <= 32'd0;
    end else begin
      RegWrite <= xfer && sel_nonzero;
      if (xfer && sel_nonzero) begin
        write_reg  <= sel_reg;
        write_data <= sel_data;
      end
    end
  end

  // Sticky error for a write to a register that had no outstanding reservation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_unreserved <= 1'b0;
    end else if (xfer && sel_nonzero && !pend_full[sel_reg]) begin
      err_unreserved <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Randomized and directed bench for regwrite_arbiter against a behavioural
// scoreboard/arbitration model.
module tb_regwrite_arbiter;

  logic        clock;
  logic        reset;
  logic        req0_valid;
  logic [4:0]  req0_reg;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_reg;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        reserve_valid;
  logic [4:0]  reserve_reg;
  logic [4:0]  query_reg1;
  logic [4:0]  query_reg2;
  logic        hazard1;
  logic        hazard2;
  logic        RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        err_unreserved;

  regwrite_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .req0_valid     (req0_valid),
    .req0_reg       (req0_reg),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_reg       (req1_reg),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .reserve_valid  (reserve_valid),
    .reserve_reg    (reserve_reg),
    .query_reg1     (query_reg1),
    .query_reg2     (query_reg2),
    .hazard1        (hazard1),
    .hazard2        (hazard2),
    .RegWrite       (RegWrite),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .err_unreserved (err_unreserved)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit          m_pend [32];
  int          m_prio;
  bit          m_err;
  bit          m_we;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  int          m_win;

  // Last sampled combinational outputs
  logic s_rdy0, s_rdy1, s_hz1, s_hz2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_prio  = 0;
    m_err   = 1'b0;
    m_we    = 1'b0;
    m_wreg  = 5'd0;
    m_wdata = 32'd0;
    m_win   = -1;
  endtask

  task automatic set_idle();
    req0_valid    = 1'b0;
    req0_reg      = 5'd0;
    req0_data     = 32'd0;
    req1_valid    = 1'b0;
    req1_reg      = 5'd0;
    req1_data     = 32'd0;
    reserve_valid = 1'b0;
    reserve_reg   = 5'd0;
    query_reg1    = 5'd0;
    query_reg2    = 5'd0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registered outputs after the edge.
  task automatic cycle();
    int         win;
    logic [4:0] r;
    bit         e1, e2;
    @(negedge clock);
    if (req0_valid && req1_valid) win = m_prio;
    else if (req0_valid)          win = 0;
    else if (req1_valid)          win = 1;
    else                          win = -1;
    e1 = (query_reg1 != 5'd0) && m_pend[query_reg1];
    e2 = (query_reg2 != 5'd0) && m_pend[query_reg2];
    s_rdy0 = req0_ready;
    s_rdy1 = req1_ready;
    s_hz1  = hazard1;
    s_hz2  = hazard2;
    chk("ready0",  32'(req0_ready), 32'(win == 0));
    chk("ready1",  32'(req1_ready), 32'(win == 1));
    chk("hazard1", 32'(hazard1), 32'(e1));
    chk("hazard2", 32'(hazard2), 32'(e2));
    m_we = 1'b0;
    if (win >= 0) begin
      r = (win == 0) ? req0_reg : req1_reg;
      if (r != 5'd0) begin
        if (!m_pend[r]) m_err = 1'b1;
        m_pend[r] = 1'b0;
        m_we    = 1'b1;
        m_wreg  = r;
        m_wdata = (win == 0) ? req0_data : req1_data;
      end
      m_prio = 1 - win;
    end
    if (reserve_valid && reserve_reg != 5'd0) m_pend[reserve_reg] = 1'b1;
    m_win = win;
    @(posedge clock);
    #1;
    chk("regwrite",   32'(RegWrite), 32'(m_we));
    chk("write_reg",  32'(write_reg), 32'(m_wreg));
    chk("write_data", write_data, m_wdata);
    chk("err",        32'(err_unreserved), 32'(m_err));
  endtask

  // Called at posedge+1: assert reset between edges, check immediate effect, release at next posedge+1.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_ready0",   32'(req0_ready), 32'd0);
    chk("rst_ready1",   32'(req1_ready), 32'd0);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_wreg",     32'(write_reg), 32'd0);
    chk("rst_wdata",    write_data, 32'd0);
    chk("rst_err",      32'(err_unreserved), 32'd0);
    chk("rst_hazard1",  32'(hazard1), 32'd0);
    chk("rst_hazard2",  32'(hazard2), 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    model_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("init_regwrite", 32'(RegWrite), 32'd0);
    chk("init_err",      32'(err_unreserved), 32'd0);
    reset = 1'b0;

    // Reserve r5, then requester 0 writes r5
    do_reset();
    set_idle();
    reserve_valid = 1'b1; reserve_reg = 5'd5; query_reg1 = 5'd5;
    cycle();
    chk("d21_no_fwd", 32'(s_hz1), 32'd0);
    reserve_valid = 1'b0;
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'h1234;
    cycle();
    chk("d21_ready0", 32'(s_rdy0), 32'd1);
    chk("d21_hz_pre", 32'(s_hz1), 32'd1);
    chk("d21_we",     32'(RegWrite), 32'd1);
    chk("d21_wreg",   32'(write_reg), 32'd5);
    chk("d21_wdata",  write_data, 32'h1234);
    set_idle(); query_reg1 = 5'd5;
    cycle();
    chk("d21_hz_post", 32'(s_hz1), 32'd0);
    chk("d21_we_drop", 32'(RegWrite), 32'd0);
    chk("d21_hold",    write_data, 32'h1234);

    // Both requesters contend: grants alternate 0,1,0,1
    do_reset();
    set_idle();
    reserve_valid = 1'b1; reserve_reg = 5'd3; cycle();
    reserve_reg = 5'd4; cycle();
    reserve_valid = 1'b0;
    req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'hAAAA0003;
    req1_valid = 1'b1; req1_reg = 5'd4; req1_data = 32'hBBBB0004;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("d22_grant0", 32'(s_rdy0), 32'(i % 2 == 0));
      chk("d22_we",     32'(RegWrite), 32'd1);
      chk("d22_wreg",   32'(write_reg), (i % 2 == 0) ? 32'd3 : 32'd4);
    end

    // Same-cycle reserve and write of r7: set wins, write proceeds
    do_reset();
    set_idle();
    reserve_valid = 1'b1; reserve_reg = 5'd7; cycle();
    req1_valid = 1'b1; req1_reg = 5'd7; req1_data = 32'hC0DE0007; query_reg1 = 5'd7;
    cycle();
    chk("d23_we",   32'(RegWrite), 32'd1);
    chk("d23_wreg", 32'(write_reg), 32'd7);
    set_idle(); query_reg1 = 5'd7;
    cycle();
    chk("d23_hz", 32'(s_hz1), 32'd1);

    // Write to r0 is accepted but dropped
    do_reset();
    set_idle();
    req0_valid = 1'b1; req0_reg = 5'd0; req0_data = 32'hFFFFFFFF;
    cycle();
    chk("d24_ready0", 32'(s_rdy0), 32'd1);
    chk("d24_we",     32'(RegWrite), 32'd0);
    chk("d24_err",    32'(err_unreserved), 32'd0);

    // Unreserved write sets sticky error
    do_reset();
    set_idle();
    req1_valid = 1'b1; req1_reg = 5'd9; req1_data = 32'h99;
    cycle();
    chk("d25_err",  32'(err_unreserved), 32'd1);
    chk("d25_we",   32'(RegWrite), 32'd1);
    set_idle();
    cycle(); cycle();
    chk("d25_hold", 32'(err_unreserved), 32'd1);

    // Reset between edges while a transfer is granted
    do_reset();
    set_idle();
    reserve_valid = 1'b1; reserve_reg = 5'd6; cycle();
    reserve_reg = 5'd10;
    req0_valid = 1'b1; req0_reg = 5'd6; req0_data = 32'h6666;
    query_reg1 = 5'd6; query_reg2 = 5'd10;
    cycle();
    chk("d26_we_pre", 32'(RegWrite), 32'd1);
    reserve_valid = 1'b0;
    do_reset();
    set_idle();
    cycle();
    chk("d26_no_write", 32'(RegWrite), 32'd0);

    // Randomized traffic with held requests and occasional resets
    do_reset();
    set_idle();
    for (int it = 0; it < 600; it++) begin
      if (!req0_valid || m_win == 0) begin
        req0_valid = ($urandom % 4) != 0;
        req0_reg   = 5'($urandom_range(0, 7));
        req0_data  = $urandom;
      end
      if (!req1_valid || m_win == 1) begin
        req1_valid = ($urandom % 4) != 0;
        req1_reg   = 5'($urandom_range(0, 7));
        req1_data  = $urandom;
      end
      reserve_valid = ($urandom % 2) != 0;
      reserve_reg   = 5'($urandom_range(0, 7));
      query_reg1    = 5'($urandom_range(0, 7));
      query_reg2    = 5'($urandom_range(0, 7));
      cycle();
      if (it % 150 == 149) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
